// File: rtl/div_unit_pkg.sv
// Shared core defines for the iterative divider.
// State encodings and the divide-by-zero quotient pattern.
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Wide enough for any supported WIDTH; the divider slices what it needs.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU beside the execute-stage ALU.
// Quotient lands in lo, remainder in hi, after a fixed WIDTH+1 cycle run.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import div_unit_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t state;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] a_q;
    logic             qsign_q;
    logic             rsign_q;
    logic             dz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] x,
        input logic             s
    );
        return (s && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    // Partial remainder stays below the divisor, so the extra top bit of
    // the trial difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        qbit    = ~diff[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ready   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        rem_q   <= '0;
                        dvd_q   <= mag(a, signed_div);
                        dvs_q   <= mag(b, signed_div);
                        a_q     <= a;
                        qsign_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rsign_q <= signed_div & a[WIDTH-1];
                        dz_q    <= (b == '0);
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem_q <= qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                        dvd_q <= {dvd_q[WIDTH-2:0], qbit};
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        ready <= 1'b1;
                        if (dz_q) begin
                            lo <= DIV0_QUOT[WIDTH-1:0];
                            hi <= a_q;
                        end else begin
                            lo <= qsign_q ? neg(dvd_q) : dvd_q;
                            hi <= rsign_q ? neg(rem_q) : rem_q;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Each scenario task drives stimulus and checks its own expectations.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .busy       (busy),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one edge, then scramble the operand inputs.
    task automatic issue(input logic sd, input logic [31:0] x, input logic [31:0] y);
        signed_div = sd;
        a          = x;
        b          = y;
        start      = 1'b1;
        step();
        start      = 1'b0;
        signed_div = ~sd;
        a          = $urandom;
        b          = $urandom;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ready !== 1'b1 && n < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", ready);
        end
        checks++;
        if (hi !== 32'h0) begin
            failures++;
            $display("FAIL reset_hi got=%h exp=00000000", hi);
        end
        checks++;
        if (lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_lo got=%h exp=00000000", lo);
        end
    endtask

    task automatic test_divu_basic();
        int n;
        int nb;
        issue(1'b0, 32'd100, 32'd7);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_accept got=%b exp=1", busy);
        end
        n  = 0;
        nb = 1;
        do begin
            step();
            n++;
            if (busy === 1'b1) nb++;
        end while (ready !== 1'b1 && n < 100);
        checks++;
        if (n !== 33) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=33", n);
        end
        checks++;
        if (nb !== 33) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d exp=33", nb);
        end
        checks++;
        if (lo !== 32'd14) begin
            failures++;
            $display("FAIL basic_lo got=%h exp=%h", lo, 32'd14);
        end
        checks++;
        if (hi !== 32'd2) begin
            failures++;
            $display("FAIL basic_hi got=%h exp=%h", hi, 32'd2);
        end
        step();
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_pulse got=%b exp=0", ready);
        end
        step();
        step();
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            failures++;
            $display("FAIL basic_hold got=%h/%h exp=%h/%h", hi, lo, 32'd2, 32'd14);
        end
    endtask

    task automatic test_signed();
        int n;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_ready(n);
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || n !== 33) begin
            failures++;
            $display("FAIL sdiv_neg7_2 got=%h/%h n=%0d exp=ffffffff/fffffffd n=33", hi, lo, n);
        end
        step();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_ready(n);
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'd1 || n !== 33) begin
            failures++;
            $display("FAIL sdiv_7_neg2 got=%h/%h n=%0d exp=00000001/fffffffd n=33", hi, lo, n);
        end
        step();
        issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        wait_ready(n);
        checks++;
        if (lo !== 32'd14 || hi !== 32'hFFFF_FFFE || n !== 33) begin
            failures++;
            $display("FAIL sdiv_neg100_neg7 got=%h/%h n=%0d exp=fffffffe/0000000e n=33", hi, lo, n);
        end
        step();
    endtask

    task automatic test_overflow();
        int n;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(n);
        checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0 || n !== 33) begin
            failures++;
            $display("FAIL sdiv_overflow got=%h/%h n=%0d exp=00000000/80000000 n=33", hi, lo, n);
        end
        step();
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_ready(n);
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h0 || n !== 33) begin
            failures++;
            $display("FAIL divu_max_1 got=%h/%h n=%0d exp=00000000/ffffffff n=33", hi, lo, n);
        end
        step();
    endtask

    task automatic test_div_zero();
        int n;
        issue(1'b0, 32'h1234_5678, 32'h0);
        wait_ready(n);
        checks++;
        if (n !== 33) begin
            failures++;
            $display("FAIL div0_latency got=%0d exp=33", n);
        end
        checks++;
        if (lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div0_lo got=%h exp=ffffffff", lo);
        end
        checks++;
        if (hi !== 32'h1234_5678) begin
            failures++;
            $display("FAIL div0_hi got=%h exp=12345678", hi);
        end
        step();
    endtask

    task automatic test_cancel();
        bit seen;
        issue(1'b0, 32'd50, 32'd5);
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL cancel_busy got=%b exp=0", busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL cancel_no_ready got=%b exp=0", seen);
        end
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678) begin
            failures++;
            $display("FAIL cancel_hold got=%h/%h exp=12345678/ffffffff", hi, lo);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) step();
        signed_div = 1'b1;
        a          = 32'd50;
        b          = 32'd5;
        start      = 1'b1;
        step();
        start      = 1'b0;
        wait_ready(n);
        checks++;
        if (n !== 28) begin
            failures++;
            $display("FAIL ignored_latency got=%0d exp=28", n);
        end
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            failures++;
            $display("FAIL ignored_result got=%h/%h exp=00000002/0000000e", hi, lo);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        issue(1'b0, 32'd1000, 32'd10);
        wait_ready(n);
        checks++;
        if (lo !== 32'd100 || hi !== 32'd0 || n !== 33) begin
            failures++;
            $display("FAIL b2b_first got=%h/%h n=%0d exp=00000000/00000064 n=33", hi, lo, n);
        end
        issue(1'b0, 32'hFFFF_FFFF, 32'd16);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept got=%b exp=1", busy);
        end
        wait_ready(n);
        checks++;
        if (lo !== 32'h0FFF_FFFF || hi !== 32'hF || n !== 33) begin
            failures++;
            $display("FAIL b2b_second got=%h/%h n=%0d exp=0000000f/0fffffff n=33", hi, lo, n);
        end
        step();
    endtask

    task automatic test_rst_mid_run();
        issue(1'b0, 32'd77, 32'd3);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_run_ctrl got=%b%b exp=00", busy, ready);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL rst_run_result got=%h/%h exp=00000000/00000000", hi, lo);
        end
    endtask

    task automatic test_start_cancel_idle();
        bit seen;
        signed_div = 1'b0;
        a          = 32'd9;
        b          = 32'd3;
        start      = 1'b1;
        cancel     = 1'b1;
        step();
        start      = 1'b0;
        cancel     = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_cancel_busy got=%b exp=0", busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL start_cancel_idle got=%b lo=%h exp=0 lo=00000000", seen, lo);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        cancel     = 1'b0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_overflow();
        test_div_zero();
        test_cancel();
        test_start_ignored();
        test_back_to_back();
        test_rst_mid_run();
        test_start_cancel_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle divider for MIPS DIV/DIVU. Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation through a start/busy handshake. Produces quotient (LO) and remainder (HI) after a fixed latency.
- The pipeline stalls on busy and supports cancellation for exception flush.

Parameters:
- WIDTH, 32, operand/result width; the counter width is derived as clog2(WIDTH)+1.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a division; sampled only when not busy
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- a  input  WIDTH  dividend
- b  input  WIDTH  divisor
- cancel  input  1  abort the operation in flight (pipeline flush)
- busy  output  1  operation in progress; the stage must stall
- ready  output  1  one-cycle pulse when hi/lo hold a new result
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, ready=0, hi=0, lo=0; counter=0. Reset wins over all other inputs.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1 and cancel=0.
  - At the accepting edge, capture |a| and |b| (magnitudes when signed_div=1, raw otherwise).
  - Also capture quotient sign = a[W-1]^b[W-1] and remainder sign = a[W-1] (both forced 0 when unsigned).
  - Capture a divide-by-zero flag (b==0). Set counter=0.
- RUN: one restoring step per cycle.
  - Shift the partial remainder left, bringing in the next dividend bit, MSB first.
  - Trial-subtract the divisor using a WIDTH+1-bit subtraction.
  - If the result is non-negative, keep it and set the quotient bit to 1.
  - counter increments each cycle. After WIDTH cycles -> DONE.
- DONE (one cycle):
  - Apply sign fix: lo = negated quotient if the quotient sign is set; hi = negated remainder if the remainder sign is set.
  - ready=1 for exactly this cycle, then -> IDLE.
  - hi/lo hold their value until the next completed operation.
- Divide by zero: takes the full latency. Result is lo=all ones, hi=a (the original, unsigned-interpreted a). No trap.
- Signed overflow 0x80000000 / 0xFFFFFFFF: falls out naturally as lo=0x80000000, hi=0. No special case.
- Latency: start accepted at edge T0; busy=1 from T0+ through the DONE cycle; ready=1 during the cycle after edge T0+WIDTH+1, i.e. 33 edges after acceptance for WIDTH=32.
- busy=1 in RUN and DONE, 0 in IDLE.
- start while busy is ignored: no queuing, operands not re-captured.
- A new start is accepted in IDLE on the cycle after ready, giving back-to-back throughput of one operation per WIDTH+2 cycles.
- cancel=1 in RUN or DONE: next state IDLE, ready stays 0, hi/lo keep their previous result.
- cancel=1 in IDLE has no effect. start and cancel in the same IDLE cycle: cancel wins and nothing is accepted.
- a/b/signed_div may change freely after acceptance; only the captured copies are used.
- Arithmetic: magnitude negation is two's complement modulo 2^WIDTH, so |0x80000000| = 0x80000000 treated as unsigned.

Decomposition:
- Shared package (the existing core-defines include): state encodings IDLE/RUN/DONE, and the divide-by-zero result constant (all ones).
- Single module, no sub-module.
- Negation helpers are an inline function.
- The restoring step is inline combinational logic feeding the RUN register update.

Test Plan:
- DIVU a=100, b=7: busy high for 33 cycles, ready pulse at edge 33 -> lo=14, hi=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=7, b=-2 -> lo=-3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0xFFFFFFFF, b=1 -> lo=0xFFFFFFFF, hi=0.
- DIVU a=0x12345678, b=0 -> full latency, lo=0xFFFFFFFF, hi=0x12345678, no X.
- Control corner cases:
  - start a=50/b=5, then cancel at cycle 10 -> busy falls next cycle, no ready, hi/lo keep the prior result.
  - start asserted at cycle 5 with different operands -> ignored.
  - Immediate restart after ready produces the correct second result.
- Reset cases:
  - rst mid-RUN -> next cycle busy=0, ready=0, hi=lo=0.
  - start and cancel asserted together in IDLE -> busy stays 0.
